// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - dispatch, resolve, training and flush signals of the branch resolve queue
interface branch_resolve_queue_if #(
  parameter int AW = 32,
  parameter int TW = 3
);
  logic          disp_brq_en_in;
  logic [AW-1:0] disp_brq_pc_in;
  logic          disp_brq_taken_in;
  logic [AW-1:0] disp_brq_target_in;
  logic [TW-1:0] brq_disp_tag_out;
  logic          brq_disp_full_out;
  logic          alu_brq_en_in;
  logic [TW-1:0] alu_brq_tag_in;
  logic          alu_brq_taken_in;
  logic [AW-1:0] alu_brq_target_in;
  logic          brq_bp_en_out;
  logic          brq_bp_correct_out;
  logic [AW-1:0] brq_bp_pc_out;
  logic          brq_flush_out;
  logic [AW-1:0] brq_flush_pc_out;

  modport slave (
    input  disp_brq_en_in, disp_brq_pc_in, disp_brq_taken_in, disp_brq_target_in,
    input  alu_brq_en_in, alu_brq_tag_in, alu_brq_taken_in, alu_brq_target_in,
    output brq_disp_tag_out, brq_disp_full_out,
    output brq_bp_en_out, brq_bp_correct_out, brq_bp_pc_out,
    output brq_flush_out, brq_flush_pc_out
  );

  modport master (
    output disp_brq_en_in, disp_brq_pc_in, disp_brq_taken_in, disp_brq_target_in,
    output alu_brq_en_in, alu_brq_tag_in, alu_brq_taken_in, alu_brq_target_in,
    input  brq_disp_tag_out, brq_disp_full_out,
    input  brq_bp_en_out, brq_bp_correct_out, brq_bp_pc_out,
    input  brq_flush_out, brq_flush_pc_out
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch tracker with out-of-order resolution, predictor training and flush
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int TW    = $clog2(DEPTH)
) (
  input logic                   clk_in,
  input logic                   rst_in,
  input logic                   rdy_in,
  branch_resolve_queue_if.slave brq
);
  localparam logic [TW:0] FULL_COUNT = (TW+1)'(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] resolved;
  logic [DEPTH-1:0] pred_taken;
  logic [DEPTH-1:0] act_taken;
  logic [AW-1:0]    pc_mem          [DEPTH];
  logic [AW-1:0]    pred_target_mem [DEPTH];
  logic [AW-1:0]    act_target_mem  [DEPTH];
  logic [TW-1:0]    head;
  logic [TW-1:0]    tail;
  logic [TW:0]      count;

  logic          bp_en_q;
  logic          bp_correct_q;
  logic [AW-1:0] bp_pc_q;
  logic          flush_q;
  logic [AW-1:0] flush_pc_q;

  logic          full;
  logic          do_alloc;
  logic          do_resolve;
  logic          do_retire;
  logic          mispredict;
  logic [AW-1:0] head_pc;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] pred_npc;
  logic [AW-1:0] act_npc;

  // Retire decisions use only registered state, so a resolve lands one edge before its retire.
  always_comb begin
    full       = (count == FULL_COUNT);
    do_alloc   = rdy_in && brq.disp_brq_en_in && !full;
    do_resolve = rdy_in && brq.alu_brq_en_in && valid[brq.alu_brq_tag_in];
    do_retire  = rdy_in && valid[head] && resolved[head];
    head_pc    = pc_mem[head];
    seq_pc     = head_pc + AW'(4);
    pred_npc   = pred_taken[head] ? pred_target_mem[head] : seq_pc;
    act_npc    = act_taken[head]  ? act_target_mem[head]  : seq_pc;
    mispredict = do_retire && (pred_npc != act_npc);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid        <= '0;
      resolved     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      bp_en_q      <= 1'b0;
      bp_correct_q <= 1'b0;
      bp_pc_q      <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
    end else if (!rdy_in) begin
      bp_en_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      bp_en_q <= do_retire;
      flush_q <= mispredict;
      if (do_retire) begin
        bp_correct_q <= (pred_taken[head] == act_taken[head]);
        bp_pc_q      <= head_pc;
      end
      if (mispredict) begin
        // Redirect wins over any allocation or resolution arriving this cycle.
        flush_pc_q <= act_npc;
        valid      <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (do_alloc) begin
          valid[tail]           <= 1'b1;
          resolved[tail]        <= 1'b0;
          pc_mem[tail]          <= brq.disp_brq_pc_in;
          pred_taken[tail]      <= brq.disp_brq_taken_in;
          pred_target_mem[tail] <= brq.disp_brq_target_in;
          tail                  <= tail + TW'(1);
        end
        if (do_resolve) begin
          resolved[brq.alu_brq_tag_in]       <= 1'b1;
          act_taken[brq.alu_brq_tag_in]      <= brq.alu_brq_taken_in;
          act_target_mem[brq.alu_brq_tag_in] <= brq.alu_brq_target_in;
        end
        if (do_retire) begin
          valid[head] <= 1'b0;
          head        <= head + TW'(1);
        end
        case ({do_alloc, do_retire})
          2'b10:   count <= count + (TW+1)'(1);
          2'b01:   count <= count - (TW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign brq.brq_disp_tag_out   = tail;
  assign brq.brq_disp_full_out  = full;
  assign brq.brq_bp_en_out      = bp_en_q;
  assign brq.brq_bp_correct_out = bp_correct_q;
  assign brq.brq_bp_pc_out      = bp_pc_q;
  assign brq.brq_flush_out      = flush_q;
  assign brq.brq_flush_pc_out   = flush_pc_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed and randomized checks of branch_resolve_queue against a queue model
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int TW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.AW(AW), .TW(TW)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .AW(AW), .TW(TW)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .brq(bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ptgt;
    logic [31:0] atgt;
    logic        pt;
    logic        at;
    logic        res;
  } ent_t;

  ent_t        mq[$];
  int          m_head = 0;
  logic        m_en = 0, m_cor = 0, m_fl = 0;
  logic [31:0] m_pc = 0, m_fpc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.disp_brq_en_in     = 1'b0;
    bus.disp_brq_pc_in     = '0;
    bus.disp_brq_taken_in  = 1'b0;
    bus.disp_brq_target_in = '0;
    bus.alu_brq_en_in      = 1'b0;
    bus.alu_brq_tag_in     = '0;
    bus.alu_brq_taken_in   = 1'b0;
    bus.alu_brq_target_in  = '0;
  endtask

  task automatic alloc_in(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    bus.disp_brq_en_in     = 1'b1;
    bus.disp_brq_pc_in     = pc;
    bus.disp_brq_taken_in  = t;
    bus.disp_brq_target_in = tg;
  endtask

  task automatic res_in(input int tag, input logic t, input logic [31:0] tg);
    bus.alu_brq_en_in     = 1'b1;
    bus.alu_brq_tag_in    = TW'(tag);
    bus.alu_brq_taken_in  = t;
    bus.alu_brq_target_in = tg;
  endtask

  // Program-order queue: element 0 is the oldest branch, whose tag is m_head.
  task automatic model_edge();
    logic        ret;
    logic [31:0] pn, an;
    int          idx;
    ent_t        e;
    if (!rst) begin
      mq.delete();
      m_head = 0;
      m_en = 0; m_cor = 0; m_pc = 0; m_fl = 0; m_fpc = 0;
    end else if (!rdy) begin
      m_en = 0;
      m_fl = 0;
    end else begin
      ret  = (mq.size() > 0) && mq[0].res;
      m_en = ret;
      m_fl = 0;
      if (ret) begin
        m_cor = (mq[0].pt == mq[0].at);
        m_pc  = mq[0].pc;
        pn = mq[0].pt ? mq[0].ptgt : mq[0].pc + 32'd4;
        an = mq[0].at ? mq[0].atgt : mq[0].pc + 32'd4;
        if (pn != an) begin
          m_fl  = 1;
          m_fpc = an;
        end
      end
      if (m_fl) begin
        mq.delete();
        m_head = 0;
      end else begin
        if (bus.alu_brq_en_in) begin
          idx = (int'(bus.alu_brq_tag_in) - m_head + DEPTH) % DEPTH;
          if (idx < mq.size()) begin
            mq[idx].res  = 1;
            mq[idx].at   = bus.alu_brq_taken_in;
            mq[idx].atgt = bus.alu_brq_target_in;
          end
        end
        if (bus.disp_brq_en_in && mq.size() < DEPTH) begin
          e.pc = bus.disp_brq_pc_in; e.pt = bus.disp_brq_taken_in; e.ptgt = bus.disp_brq_target_in;
          e.res = 0; e.at = 0; e.atgt = 0;
          mq.push_back(e);
        end
        if (ret) begin
          void'(mq.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("tag", bus.brq_disp_tag_out, (m_head + mq.size()) % DEPTH);
    check("full", bus.brq_disp_full_out, mq.size() == DEPTH);
    check("bp_en", bus.brq_bp_en_out, m_en);
    check("bp_correct", bus.brq_bp_correct_out, m_cor);
    check("bp_pc", bus.brq_bp_pc_out, m_pc);
    check("flush", bus.brq_flush_out, m_fl);
    check("flush_pc", bus.brq_flush_pc_out, m_fpc);
    idle();
  endtask

  initial begin
    logic [31:0] wpc[11];
    logic        wpt[11];
    logic [31:0] wtg[11];
    logic [31:0] got[$];
    int          ord[5];
    int          pulses;
    int          idx;

    idle();
    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy = 1'($urandom);
      alloc_in($urandom, 1'($urandom), $urandom);
      res_in($urandom_range(0, DEPTH - 1), 1'($urandom), $urandom);
      step();
    end
    check("rst_full", bus.brq_disp_full_out, 0);
    check("rst_tag", bus.brq_disp_tag_out, 0);
    check("rst_bp_en", bus.brq_bp_en_out, 0);
    check("rst_flush", bus.brq_flush_out, 0);
    check("rst_flush_pc", bus.brq_flush_pc_out, 0);
    check("rst_bp_pc", bus.brq_bp_pc_out, 0);
    rst = 1'b1;
    rdy = 1'b1;

    // Correct not-taken
    alloc_in(32'h100, 1'b0, 32'h200); step();
    res_in(0, 1'b0, 32'h0); step();
    step();
    check("nt_en", bus.brq_bp_en_out, 1);
    check("nt_correct", bus.brq_bp_correct_out, 1);
    check("nt_pc", bus.brq_bp_pc_out, 32'h100);
    check("nt_flush", bus.brq_flush_out, 0);
    step();
    check("nt_pulse_end", bus.brq_bp_en_out, 0);

    // Mispredict: taken predicted, not taken actual
    alloc_in(32'h40, 1'b1, 32'h80); step();
    res_in(1, 1'b0, 32'h0); step();
    step();
    check("mp_en", bus.brq_bp_en_out, 1);
    check("mp_correct", bus.brq_bp_correct_out, 0);
    check("mp_flush", bus.brq_flush_out, 1);
    check("mp_flush_pc", bus.brq_flush_pc_out, 32'h44);
    check("mp_tag", bus.brq_disp_tag_out, 0);
    check("mp_full", bus.brq_disp_full_out, 0);
    step();
    check("mp_flush_end", bus.brq_flush_out, 0);

    // Fill, refuse, wrap, out-of-order resolve
    for (int i = 0; i < 11; i++) begin
      wpc[i] = 32'h1000 + 32'(16 * i);
      wpt[i] = 1'(i);
      wtg[i] = 32'h2000 + 32'(16 * i);
    end
    for (int i = 0; i < 8; i++) begin
      alloc_in(wpc[i], wpt[i], wtg[i]); step();
    end
    check("wr_full", bus.brq_disp_full_out, 1);
    alloc_in(32'hdead, 1'b0, 32'h0); step();
    check("wr_refused_full", bus.brq_disp_full_out, 1);
    check("wr_refused_tag", bus.brq_disp_tag_out, 0);
    for (int t = 0; t < 3; t++) begin
      res_in(t, wpt[t], wtg[t]); step();
    end
    step(); step();
    for (int i = 8; i < 11; i++) begin
      check("wr_tag_wrap", bus.brq_disp_tag_out, i - 8);
      alloc_in(wpc[i], wpt[i], wtg[i]); step();
    end
    ord = '{7, 5, 3, 4, 6};
    got.delete();
    for (int k = 0; k < 15; k++) begin
      if (k < 5) res_in(ord[k], wpt[ord[k]], wtg[ord[k]]);
      step();
      if (bus.brq_bp_en_out) got.push_back(bus.brq_bp_pc_out);
    end
    check("wr_pulse_count", got.size(), 5);
    for (int k = 0; k < 5; k++)
      check("wr_order", (k < got.size()) ? got[k] : 32'hx, wpc[3 + k]);
    rst = 1'b0; step(); rst = 1'b1;

    // Right direction, wrong target
    alloc_in(32'h10, 1'b1, 32'h20); step();
    res_in(0, 1'b1, 32'h30); step();
    step();
    check("wt_en", bus.brq_bp_en_out, 1);
    check("wt_correct", bus.brq_bp_correct_out, 1);
    check("wt_flush", bus.brq_flush_out, 1);
    check("wt_flush_pc", bus.brq_flush_pc_out, 32'h30);
    step();

    // rdy stall on a resolved head
    alloc_in(32'h500, 1'b0, 32'h600); step();
    res_in(0, 1'b0, 32'h0); step();
    pulses = 0;
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("st_no_pulse", bus.brq_bp_en_out, 0);
      pulses += int'(bus.brq_bp_en_out);
    end
    rdy = 1'b1;
    step();
    check("st_pulse", bus.brq_bp_en_out, 1);
    check("st_pc", bus.brq_bp_pc_out, 32'h500);
    pulses += int'(bus.brq_bp_en_out);
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(bus.brq_bp_en_out);
    end
    check("st_one_pulse", pulses, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom % 64) != 0;
      rdy = ($urandom % 10) != 0;
      if ($urandom % 2)
        alloc_in({$urandom_range(0, 255), 2'b00}, 1'($urandom),
                 ($urandom % 2) ? 32'h100 : 32'h200);
      if (($urandom % 10) < 6) begin
        if (mq.size() > 0 && ($urandom % 4) != 0) begin
          idx = $urandom_range(0, mq.size() - 1);
          res_in((m_head + idx) % DEPTH, mq[idx].pt,
                 (($urandom % 3) == 0) ? 32'h300 : mq[idx].ptgt);
        end else begin
          res_in($urandom_range(0, DEPTH - 1), 1'($urandom), 32'h100);
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker for predicted control-flow instructions, sitting between the dispatcher/ALU and the branch predictor. It records each dispatched branch's PC and prediction, collects out-of-order resolutions from the ALU by tag, and retires entries in program order. On retirement it drives the predictor's training port (enable/correct/pc) and, on a wrong next-PC, a one-cycle pipeline flush with the redirect PC.

## Interface

- DEPTH, 8, entry count; power of two, at least 2
- AW, 32, address width
- TW, log2(DEPTH), tag width
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-low reset
- rdy_in  input  1  global ready; when low, state holds
- disp_brq_en_in  input  1  allocate an entry this cycle
- disp_brq_pc_in  input  AW  branch PC
- disp_brq_taken_in  input  1  predicted direction
- disp_brq_target_in  input  AW  taken-path target
- brq_disp_tag_out  output  TW  tag granted to the current allocation (= tail pointer)
- brq_disp_full_out  output  1  queue full; allocation is refused
- alu_brq_en_in  input  1  resolution valid
- alu_brq_tag_in  input  TW  tag being resolved
- alu_brq_taken_in  input  1  actual direction
- alu_brq_target_in  input  AW  actual taken-path target
- brq_bp_en_out  output  1  predictor training pulse
- brq_bp_correct_out  output  1  direction prediction was correct
- brq_bp_pc_out  output  AW  PC of the retired branch
- brq_flush_out  output  1  mispredict flush pulse
- brq_flush_pc_out  output  AW  redirect PC

## Operation

- Each entry holds: valid, resolved, pc, pred_taken, pred_target, act_taken, act_target. Pointers: head and tail, each TW bits wide and wrapping modulo DEPTH. Count is TW+1 bits wide.
- Full is `count == DEPTH`. It is combinational from registered state.
- **Allocate:** when disp_brq_en_in and not full, write the entry at tail with valid=1 and resolved=0, then increment tail. Allocation while full is dropped silently. The dispatcher must not assert en while full.
- **Resolve:** when alu_brq_en_in and the entry at the tag is valid, set resolved=1 and store act_taken and act_target. A resolve to an invalid tag is ignored. A second resolve to the same tag overwrites the first.
- **Retire:** at most one per cycle. An entry retires when the head entry is both valid and resolved. Retiring clears its valid bit and increments head.
- **Retire outputs:**
  - brq_bp_en_out = 1
  - brq_bp_pc_out = pc
  - brq_bp_correct_out = (pred_taken == act_taken)
- **Next-PC check:**
  - Predicted next PC = pred_taken ? pred_target : pc+4.
  - Actual next PC = act_taken ? act_target : pc+4.
  - The +4 is modulo 2^AW.
  - If the two differ, assert brq_flush_out=1 and set brq_flush_pc_out = actual next PC.
  - This covers a right direction with a wrong target: correct=1 but flush=1.
- **Flush:** in the same edge that registers brq_flush_out, clear all valid bits and set head=tail=count=0. Allocation and resolution in that cycle are discarded.
- **Count:** updates by +alloc −retire, so simultaneous allocate and retire leaves count unchanged. Full uses the pre-edge count, so allocation is refused in the cycle a full queue retires.
- **Reset** (rst_in=0 at an edge): all valid bits 0, pointers 0, count 0. All outputs read 0: en, correct, pc, flush, flush_pc. This holds regardless of rdy_in. Reset mid-flight discards all entries.
- **rdy_in=0:** no allocation, resolution or retirement. Registered brq_bp_en_out and brq_flush_out are driven to 0 at that edge; the pc and correct outputs hold.

## Timing

- brq_disp_tag_out and brq_disp_full_out are combinational from registers. The tag is valid in the same cycle as disp_brq_en_in.
- All predictor and flush outputs are registered. They are pulses, one cycle wide, and appear the cycle after the retiring edge's decision.
- Resolution-to-retire latency:
  - A resolve at edge N sets resolved.
  - The head retires at edge N+1.
  - brq_bp_en_out is high during cycle N+1 to N+2.
  - Minimum latency is 2 edges from the resolve input to the visible pulse.
- Back-to-back retirement: one entry per cycle when consecutive head entries are already resolved.
- An entry allocated at edge N can be resolved at the earliest at edge N+1.

## Test plan

- **Reset:** hold rst_in=0 for 2 cycles with random inputs. Then full=0, tag=0, and bp_en, flush, flush_pc and bp_pc are all 0.
- **Correct not-taken:** allocate pc=0x100, taken=0, target=0x200 (tag 0). Resolve tag 0 with taken=0. One pulse follows with bp_en=1, correct=1, pc=0x100, and flush=0.
- **Mispredict:** allocate pc=0x40, taken=1, target=0x80. Resolve with taken=0. Expect bp_en=1, correct=0, flush=1, flush_pc=0x44. The next cycle shows tag=0 and full=0.
- **Out-of-order resolution with wrap:**
  - Fill 8 entries; full=1 and a 9th allocation is refused.
  - Retire tags 0–2, then allocate 3 more; tags wrap to 0–2.
  - Resolve tags 7, 5, 3, 4, 6 in that order.
  - Retirement pulses come in tag order 3, 4, 5, 6, 7, one per cycle, and only once each predecessor is resolved.
- **Wrong target, right direction:** allocate pc=0x10, taken=1, target=0x20. Resolve taken=1, target=0x30. Expect correct=1, flush=1, flush_pc=0x30.
- **rdy_in stall:** a resolved head with rdy_in=0 for 3 cycles produces no pulse. The pulse appears the cycle after rdy_in returns to 1, and there is exactly one.
